// File: rtl/trace_replay_pkg.sv
// Shared types and default widths for the trace replay generator.
package trace_replay_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 1;
  localparam int unsigned DEF_TIME_WIDTH = 64;
  localparam int unsigned DEF_DEPTH      = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREFETCH = 2'd1,
    ST_RUN      = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  // Entry layout at the default widths; the top redeclares it at its own widths.
  typedef struct packed {
    logic [DEF_TIME_WIDTH-1:0] stamp;
    logic [DEF_DATA_WIDTH-1:0] value;
  } entry_t;

endpackage

// File: rtl/trace_replay_gen_if.sv
// Host load port of the trace replay generator: entry handshake plus clear.
interface trace_replay_gen_if
  import trace_replay_pkg::*;
#(
  parameter int unsigned TIME_WIDTH = DEF_TIME_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                  load_valid;
  logic                  load_ready;
  logic [TIME_WIDTH-1:0] load_time;
  logic [DATA_WIDTH-1:0] load_value;
  logic                  load_clear;

  modport master (
    output load_valid, load_time, load_value, load_clear,
    input  load_ready
  );

  modport slave (
    input  load_valid, load_time, load_value, load_clear,
    output load_ready
  );

endinterface

// File: rtl/trace_replay_mem.sv
// Simple dual-port entry RAM: synchronous write, registered read (1-cycle latency).
module trace_replay_mem #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned WIDTH      = 65,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read register holds its value between reads; it doubles as the replay head.
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/trace_replay_gen.sv
// Replays host-loaded (timestamp, value) events relative to the arm instant.
// Optional macro TRACE_REPLAY_LOOP_EN: restart from entry 0 after the last fire.
module trace_replay_gen
  import trace_replay_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned TIME_WIDTH = DEF_TIME_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  emu_clk,
  input  logic                  emu_rst_n,
  input  logic [TIME_WIDTH-1:0] emu_time,
  trace_replay_gen_if.slave     load_if,
  input  logic                  arm,
  input  logic                  abort,
  output logic [DATA_WIDTH-1:0] replay_value,
  output logic                  replay_strobe,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int unsigned ENTRY_WIDTH = TIME_WIDTH + DATA_WIDTH;
  localparam int unsigned CNT_WIDTH   = ADDR_WIDTH + 1;

  typedef struct packed {
    logic [TIME_WIDTH-1:0] stamp;
    logic [DATA_WIDTH-1:0] value;
  } head_t;

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    count_q, count_d;
  logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [TIME_WIDTH-1:0]   t0_q, t0_d;
  logic [DATA_WIDTH-1:0]   value_q, value_d;
  logic                    strobe_q, strobe_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    ready_q, ready_d;

  logic                    mem_we;
  logic                    mem_re;
  logic [ADDR_WIDTH-1:0]   mem_raddr;
  logic [ENTRY_WIDTH-1:0]  mem_rdata;
  head_t                   head;
  logic [TIME_WIDTH-1:0]   elapsed;
  logic                    fire;
  logic                    last;

  trace_replay_mem #(
    .DEPTH      (DEPTH),
    .WIDTH      (ENTRY_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk_i   (emu_clk),
    .we_i    (mem_we),
    .waddr_i (count_q[ADDR_WIDTH-1:0]),
    .wdata_i ({load_if.load_time, load_if.load_value}),
    .re_i    (mem_re),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  // Elapsed time wraps modulo 2^TIME_WIDTH, so a t0 near the top still works.
  assign head    = head_t'(mem_rdata);
  assign elapsed = emu_time - t0_q;
  assign fire    = (state_q == ST_RUN) && !abort && (elapsed >= head.stamp);
  assign last    = ({1'b0, rd_ptr_q} == (count_q - CNT_WIDTH'(1)));

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    t0_d      = t0_q;
    value_d   = value_q;
    strobe_d  = 1'b0;
    done_d    = done_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_raddr = '0;

    case (state_q)
      ST_IDLE: begin
        if (load_if.load_clear) begin
          count_d = '0;
          done_d  = 1'b0;
        end else if (load_if.load_valid && ready_q) begin
          mem_we  = 1'b1;
          count_d = count_q + CNT_WIDTH'(1);
        end
        if (arm) begin
          if (count_q != '0) begin
            t0_d     = emu_time;
            rd_ptr_d = '0;
            mem_re   = 1'b1;
            done_d   = 1'b0;
            state_d  = ST_PREFETCH;
          end else begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_PREFETCH: begin
        state_d = abort ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (fire) begin
          strobe_d = 1'b1;
          value_d  = head.value;
          if (last) begin
`ifdef TRACE_REPLAY_LOOP_EN
            rd_ptr_d = '0;
            t0_d     = emu_time;
            mem_re   = 1'b1;
            state_d  = ST_PREFETCH;
`else
            done_d  = 1'b1;
            state_d = ST_DONE;
`endif
          end else begin
            rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(1);
            mem_re    = 1'b1;
            mem_raddr = rd_ptr_q + ADDR_WIDTH'(1);
          end
        end
      end
      ST_DONE: begin
        if (abort) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d  = (state_d == ST_PREFETCH) || (state_d == ST_RUN);
    ready_d = (state_d == ST_IDLE) && (count_d < CNT_WIDTH'(DEPTH));
  end

  always_ff @(posedge emu_clk) begin
    if (!emu_rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      t0_q     <= '0;
      value_q  <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      t0_q     <= t0_d;
      value_q  <= value_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  assign load_if.load_ready = ready_q;
  assign replay_value       = value_q;
  assign replay_strobe      = strobe_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign count              = count_q;

endmodule

// File: tb/tb_trace_replay_gen.sv
// Directed bench for trace_replay_gen with a strobe scoreboard (cycle + value).
module tb_trace_replay_gen;

  localparam int unsigned TW    = 64;
  localparam int unsigned DW    = 1;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          emu_clk = 1'b0;
  logic          emu_rst_n;
  logic [TW-1:0] emu_time;
  logic          arm;
  logic          abort;
  logic [DW-1:0] replay_value;
  logic          replay_strobe;
  logic          busy;
  logic          done;
  logic [AW:0]   count;

  always #5 emu_clk = ~emu_clk;

  trace_replay_gen_if #(.TIME_WIDTH(TW), .DATA_WIDTH(DW)) lif ();

  trace_replay_gen #(
    .DATA_WIDTH (DW),
    .TIME_WIDTH (TW),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW)
  ) dut (
    .emu_clk       (emu_clk),
    .emu_rst_n     (emu_rst_n),
    .emu_time      (emu_time),
    .load_if       (lif),
    .arm           (arm),
    .abort         (abort),
    .replay_value  (replay_value),
    .replay_strobe (replay_strobe),
    .busy          (busy),
    .done          (done),
    .count         (count)
  );

  int checks   = 0;
  int failures = 0;
  longint unsigned cyc = 0;
  logic [TW-1:0] t_step;

  typedef struct {
    longint unsigned cyc;
    logic [DW-1:0]   value;
  } exp_t;
  exp_t sb[$];

  always @(posedge emu_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Every strobe must match the next expected (cycle, value) pair.
  always @(negedge emu_clk) begin
    if (emu_rst_n === 1'b1 && replay_strobe !== 1'b0) begin
      if (sb.size() == 0) begin
        check("strobe_unexpected", 64'(replay_strobe), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("strobe_cycle", cyc, e.cyc);
        check("strobe_value", 64'(replay_value), 64'(e.value));
      end
    end
  end

  task automatic step();
    @(posedge emu_clk);
    #1;
    emu_time = emu_time + t_step;
  endtask

  task automatic push(input longint unsigned c, input logic [DW-1:0] v);
    exp_t e;
    e.cyc   = c;
    e.value = v;
    sb.push_back(e);
  endtask

  task automatic load(input logic [TW-1:0] t, input logic [DW-1:0] v);
    lif.load_valid = 1'b1;
    lif.load_time  = t;
    lif.load_value = v;
    step();
    lif.load_valid = 1'b0;
  endtask

  task automatic arm_at(input logic [TW-1:0] t, output longint unsigned c0);
    emu_time = t;
    arm = 1'b1;
    step();
    arm = 1'b0;
    c0 = cyc;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic pulse_clear();
    lif.load_clear = 1'b1;
    step();
    lif.load_clear = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() != 0; i++) step();
    check("drain_timeout", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint unsigned c0;
    emu_rst_n      = 1'b0;
    emu_time       = '0;
    t_step         = 64'd1;
    arm            = 1'b0;
    abort          = 1'b0;
    lif.load_valid = 1'b0;
    lif.load_time  = '0;
    lif.load_value = '0;
    lif.load_clear = 1'b0;
    repeat (3) step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_strobe", 64'(replay_strobe), 64'd0);
    check("rst_value", 64'(replay_value), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_ready", 64'(lif.load_ready), 64'd1);
    emu_rst_n = 1'b1;
    step();

`ifdef TRACE_REPLAY_LOOP_EN
    load(64'd3, 1'b1);
    load(64'd6, 1'b0);
    arm_at(64'd100, c0);
    for (int k = 0; k < 3; k++) begin
      push(c0 + 3 + 6 * longint'(k), 1'b1);
      push(c0 + 6 + 6 * longint'(k), 1'b0);
    end
    wait_drain(40);
    check("loop_done_low", 64'(done), 64'd0);
    pulse_abort();
    check("loop_abort_busy", 64'(busy), 64'd0);
    repeat (20) step();
    check("loop_done_after", 64'(done), 64'd0);
`else
    // Basic replay with two equal timestamps.
    load(64'd10, 1'b1);
    load(64'd25, 1'b0);
    load(64'd25, 1'b1);
    load(64'd40, 1'b0);
    check("t1_count", 64'(count), 64'd4);
    arm_at(64'd1000, c0);
    check("t1_busy", 64'(busy), 64'd1);
    push(c0 + 10, 1'b1);
    push(c0 + 25, 1'b0);
    push(c0 + 26, 1'b1);
    push(c0 + 40, 1'b0);
    wait_drain(60);
    check("t1_done", 64'(done), 64'd1);
    check("t1_value", 64'(replay_value), 64'd0);
    check("t1_busy_end", 64'(busy), 64'd0);

    // Full memory, rejected 17th entry, then replay all 16 back to back.
    pulse_abort();
    check("t2_abort_done_kept", 64'(done), 64'd1);
    pulse_clear();
    check("t2_clear_count", 64'(count), 64'd0);
    check("t2_clear_done", 64'(done), 64'd0);
    lif.load_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      lif.load_time  = 64'(i * 3);
      lif.load_value = 1'(i % 2);
      step();
    end
    lif.load_time  = 64'd999;
    lif.load_value = 1'b1;
    step();
    step();
    lif.load_valid = 1'b0;
    check("t2_full_count", 64'(count), 64'd16);
    check("t2_full_ready", 64'(lif.load_ready), 64'd0);
    t_step = 64'd100;
    arm_at(64'd2000, c0);
    for (int i = 0; i < 16; i++) push(c0 + 2 + longint'(i), 1'(i % 2));
    wait_drain(40);
    check("t2_done", 64'(done), 64'd1);
    pulse_abort();
    pulse_clear();
    check("t2_clr_count", 64'(count), 64'd0);
    check("t2_clr_ready", 64'(lif.load_ready), 64'd1);

    // Coarse time steps: all entries overdue at once.
    load(64'd5, 1'b1);
    load(64'd7, 1'b0);
    load(64'd9, 1'b1);
    arm_at(64'd2000, c0);
    push(c0 + 2, 1'b1);
    push(c0 + 3, 1'b0);
    push(c0 + 4, 1'b1);
    wait_drain(20);
    check("t3_done", 64'(done), 64'd1);
    check("t3_value", 64'(replay_value), 64'd1);
    t_step = 64'd1;

    // Abort mid-replay, then re-arm.
    pulse_abort();
    pulse_clear();
    load(64'd10, 1'b1);
    load(64'd20, 1'b0);
    load(64'd30, 1'b1);
    load(64'd40, 1'b0);
    arm_at(64'd3000, c0);
    push(c0 + 10, 1'b1);
    push(c0 + 20, 1'b0);
    wait_drain(40);
    pulse_abort();
    check("t4_abort_busy", 64'(busy), 64'd0);
    check("t4_abort_done", 64'(done), 64'd0);
    repeat (30) step();
    check("t4_value_held", 64'(replay_value), 64'd0);
    check("t4_ready_idle", 64'(lif.load_ready), 64'd1);
    arm_at(64'd5000, c0);
    push(c0 + 10, 1'b1);
    push(c0 + 20, 1'b0);
    push(c0 + 30, 1'b1);
    push(c0 + 40, 1'b0);
    wait_drain(60);
    check("t4_done", 64'(done), 64'd1);

    // Empty arm, then emu_time wrap.
    pulse_abort();
    pulse_clear();
    arm = 1'b1;
    step();
    arm = 1'b0;
    check("t5_empty_done", 64'(done), 64'd1);
    check("t5_empty_busy", 64'(busy), 64'd0);
    pulse_abort();
    load(64'd10, 1'b1);
    check("t5_count", 64'(count), 64'd1);
    arm_at(64'hFFFF_FFFF_FFFF_FFFB, c0);
    push(c0 + 10, 1'b1);
    wait_drain(30);
    check("t5_wrap_done", 64'(done), 64'd1);
    check("t5_wrap_value", 64'(replay_value), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
